// File: rtl/xorexpand_streamer_pkg.sv
// Shared constants, sizing helpers and state encoding for the xor-expand pad streamer.
package xorexpand_streamer_pkg;

  // Seed width of the upstream xor-expand generator and the default word width.
  localparam int DEF_RNDSIZE = 16;
  localparam int DEF_OUT_W   = 8;

  // IDLE waits for a pad vector; STREAM emits it word by word.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Number of pad bits produced by an xor-expand of seed width r.
  function automatic int pad_width(input int r);
    return (r * (r - 1)) / 2;
  endfunction

  // Integer division rounded up.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/xorexpand_streamer.sv
// Captures one expanded pad vector and streams it out LSB-first as OUT_W-bit words.
module xorexpand_streamer
  import xorexpand_streamer_pkg::*;
#(
  parameter int RNDSIZE = DEF_RNDSIZE,
  parameter int OUT_W   = DEF_OUT_W,
  localparam int P_W    = pad_width(RNDSIZE),
  localparam int NWORDS = ceil_div(P_W, OUT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int BUF_W = NWORDS * OUT_W;
  localparam int CW    = clog2_min1(NWORDS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

  state_t          r_state;
  logic [BUF_W-1:0] r_buf;
  logic [CW-1:0]   r_cnt;

  logic w_stream;
  logic w_last;
  logic w_in_ready;
  logic w_accept;
  logic w_advance;

  // Handshake decode; in_ready is the only path that depends combinationally on an input.
  always_comb begin
    w_stream   = (r_state == ST_STREAM);
    w_last     = w_stream & (r_cnt == LAST_CNT);
    w_in_ready = ~w_stream | (w_last & out_ready);
    w_accept   = in_valid & w_in_ready;
    w_advance  = w_stream & out_ready;
  end

  // Load / shift / retire the pad buffer; the buffer is cleared when idle so out_data reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Covers both a load from IDLE and a zero-bubble reload on the final word.
      r_buf   <= BUF_W'(in_data);
      r_cnt   <= '0;
      r_state <= ST_STREAM;
    end else if (w_advance) begin
      if (w_last) begin
        r_buf   <= '0;
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_buf   <= r_buf >> OUT_W;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_stream;
  assign out_data  = r_buf[OUT_W-1:0];
  assign out_last  = w_last;
  assign busy      = w_stream;

endmodule

// File: tb/tb_xorexpand_streamer.sv
// Directed self-checking bench for xorexpand_streamer at three parameter points.
module tb_xorexpand_streamer;

  logic clk;
  logic rst_n;

  // Defaults: RNDSIZE=16, OUT_W=8 -> P_W=120, NWORDS=15
  logic         def_in_valid, def_in_ready, def_out_valid, def_out_ready, def_out_last, def_busy;
  logic [119:0] def_in_data;
  logic [7:0]   def_out_data;

  // RNDSIZE=4, OUT_W=4 -> P_W=6, NWORDS=2
  logic         s44_in_valid, s44_in_ready, s44_out_valid, s44_out_ready, s44_out_last, s44_busy;
  logic [5:0]   s44_in_data;
  logic [3:0]   s44_out_data;

  // RNDSIZE=4, OUT_W=8 -> P_W=6, NWORDS=1
  logic         s48_in_valid, s48_in_ready, s48_out_valid, s48_out_ready, s48_out_last, s48_busy;
  logic [5:0]   s48_in_data;
  logic [7:0]   s48_out_data;

  int checks;
  int errors;

  xorexpand_streamer #(.RNDSIZE(16), .OUT_W(8)) u_def (
    .clk(clk), .rst_n(rst_n),
    .in_valid(def_in_valid), .in_ready(def_in_ready), .in_data(def_in_data),
    .out_valid(def_out_valid), .out_ready(def_out_ready), .out_data(def_out_data),
    .out_last(def_out_last), .busy(def_busy)
  );

  xorexpand_streamer #(.RNDSIZE(4), .OUT_W(4)) u_s44 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s44_in_valid), .in_ready(s44_in_ready), .in_data(s44_in_data),
    .out_valid(s44_out_valid), .out_ready(s44_out_ready), .out_data(s44_out_data),
    .out_last(s44_out_last), .busy(s44_busy)
  );

  xorexpand_streamer #(.RNDSIZE(4), .OUT_W(8)) u_s48 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s48_in_valid), .in_ready(s48_in_ready), .in_data(s48_in_data),
    .out_valid(s48_out_valid), .out_ready(s48_out_ready), .out_data(s48_out_data),
    .out_last(s48_out_last), .busy(s48_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls forever.
  initial begin
    #500000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Byte w of a 120-bit pad vector, LSB-first.
  function automatic logic [7:0] word_of(input logic [119:0] v, input int w);
    logic [119:0] t;
    t = v >> (8 * w);
    return t[7:0];
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present v to the idle default instance and let it be accepted.
  task automatic load_def(input logic [119:0] v);
    def_in_valid = 1'b1;
    def_in_data  = v;
    #1;
    check("def_load_ready", {127'd0, def_in_ready}, 128'd1);
    step();
    def_in_valid = 1'b0;
  endtask

  // Consume all 15 words of v; optional 1,0,0 stall pattern and optional chained next vector.
  task automatic stream_def(input logic [119:0] v, input bit stall, input bit chain,
                            input logic [119:0] vnext, output int busy_cnt);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    busy_cnt = 0;
    while (idx < 15 && cyc < 200) begin
      def_out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      def_in_valid  = chain && (idx == 14) && def_out_ready;
      def_in_data   = vnext;
      #1;
      check("def_valid", {127'd0, def_out_valid}, 128'd1);
      check("def_data",  {120'd0, def_out_data}, {120'd0, word_of(v, idx)});
      check("def_last",  {127'd0, def_out_last}, {127'd0, (idx == 14)});
      check("def_in_ready", {127'd0, def_in_ready}, {127'd0, ((idx == 14) && def_out_ready)});
      if (def_busy) busy_cnt++;
      $display("word idx=%0d ready=%0b data=%02h last=%0b", idx, def_out_ready, def_out_data, def_out_last);
      if (def_out_ready) idx++;
      cyc++;
      step();
      def_in_valid = 1'b0;
    end
    check("def_word_count", 128'(idx), 128'd15);
  endtask

  logic [119:0] v_a, v_b, v_c;
  int bc;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    def_in_valid = 0; def_in_data = '0; def_out_ready = 0;
    s44_in_valid = 0; s44_in_data = '0; s44_out_ready = 0;
    s48_in_valid = 0; s48_in_data = '0; s48_out_ready = 0;
    v_a = 120'h0123456789ABCDEF0011223344556;
    v_b = 120'hA5A5_1234_5678_9ABC_DEF0_0F1E_2D3C_4B;
    v_c = 120'hFEDC_BA98_7654_3210_C3C3_7E7E_8181_99;

    step(); step();
    rst_n = 1'b1;
    #1;
    // Reset state
    check("rst_in_ready",  {127'd0, def_in_ready},  128'd1);
    check("rst_out_valid", {127'd0, def_out_valid}, 128'd0);
    check("rst_out_data",  {120'd0, def_out_data},  128'd0);
    check("rst_out_last",  {127'd0, def_out_last},  128'd0);
    check("rst_busy",      {127'd0, def_busy},      128'd0);
    check("rst_s44_ready", {127'd0, s44_in_ready},  128'd1);
    check("rst_s48_valid", {127'd0, s48_out_valid}, 128'd0);
    $display("reset done");

    // Scenario 1: RNDSIZE=4, OUT_W=4, 6'h2D -> D then 2
    s44_in_valid = 1'b1; s44_in_data = 6'h2D; s44_out_ready = 1'b1;
    step();
    s44_in_valid = 1'b0;
    #1;
    check("s44_w0_valid", {127'd0, s44_out_valid}, 128'd1);
    check("s44_w0_data",  {124'd0, s44_out_data},  128'hD);
    check("s44_w0_last",  {127'd0, s44_out_last},  128'd0);
    check("s44_w0_inrdy", {127'd0, s44_in_ready},  128'd0);
    $display("s44 word0 data=%h last=%0b", s44_out_data, s44_out_last);
    step();
    check("s44_w1_data",  {124'd0, s44_out_data},  128'h2);
    check("s44_w1_last",  {127'd0, s44_out_last},  128'd1);
    check("s44_w1_inrdy", {127'd0, s44_in_ready},  128'd1);
    $display("s44 word1 data=%h last=%0b", s44_out_data, s44_out_last);
    step();
    check("s44_idle_valid", {127'd0, s44_out_valid}, 128'd0);
    check("s44_idle_inrdy", {127'd0, s44_in_ready},  128'd1);
    check("s44_idle_data",  {124'd0, s44_out_data},  128'd0);
    check("s44_idle_busy",  {127'd0, s44_busy},      128'd0);

    // Scenario 2: full-rate stream of v_a
    load_def(v_a);
    stream_def(v_a, 1'b0, 1'b0, '0, bc);
    check("def_busy_cycles", 128'(bc), 128'd15);
    check("def_end_valid", {127'd0, def_out_valid}, 128'd0);
    check("def_end_busy",  {127'd0, def_busy},      128'd0);

    // Scenario 3: same vector with 1,0,0 backpressure
    load_def(v_a);
    stream_def(v_a, 1'b1, 1'b0, '0, bc);
    check("def_stall_end_valid", {127'd0, def_out_valid}, 128'd0);

    // Scenario 4: back-to-back v_b then v_c with no bubble
    load_def(v_b);
    stream_def(v_b, 1'b0, 1'b1, v_c, bc);
    stream_def(v_c, 1'b0, 1'b0, '0, bc);
    check("b2b_end_valid", {127'd0, def_out_valid}, 128'd0);

    // Scenario 5: reset after word 5 of v_b, then v_c streams from word 0
    load_def(v_b);
    def_out_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      #1;
      check("mid_data", {120'd0, def_out_data}, {120'd0, word_of(v_b, w)});
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", {127'd0, def_out_valid}, 128'd0);
    check("mid_rst_inrdy", {127'd0, def_in_ready},  128'd1);
    check("mid_rst_data",  {120'd0, def_out_data},  128'd0);
    $display("mid-stream reset applied");
    load_def(v_c);
    stream_def(v_c, 1'b0, 1'b0, '0, bc);

    // Scenario 6: single-word instance, in_valid ignored while stalled
    s48_in_valid = 1'b1; s48_in_data = 6'h3F; s48_out_ready = 1'b0;
    step();
    s48_in_data = 6'h15;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("s48_stall_inrdy", {127'd0, s48_in_ready},  128'd0);
      check("s48_stall_valid", {127'd0, s48_out_valid}, 128'd1);
      check("s48_stall_data",  {120'd0, s48_out_data},  128'h3F);
      check("s48_stall_last",  {127'd0, s48_out_last},  128'd1);
      $display("s48 stalled data=%h last=%0b", s48_out_data, s48_out_last);
      step();
    end
    s48_in_valid = 1'b0;
    s48_out_ready = 1'b1;
    #1;
    check("s48_hs_inrdy", {127'd0, s48_in_ready}, 128'd1);
    check("s48_hs_data",  {120'd0, s48_out_data}, 128'h3F);
    step();
    check("s48_idle_valid", {127'd0, s48_out_valid}, 128'd0);
    check("s48_idle_data",  {120'd0, s48_out_data},  128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
